// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains bytes from the read port of the team FIFO.
// Outputs are registered; tx follows the registered state one cycle later.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   tx,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] frames_sent
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud, baud_next;
    logic [BIT_W-1:0]      bit_idx, bit_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  frame_done, frame_done_next;
    logic                  baud_end;

    assign baud_end = (baud == BAUD_LAST);

    // FETCH covers the pop cycle; the FIFO word is valid in the first START cycle.
    always_comb begin
        state_next      = state;
        baud_next       = baud;
        bit_next        = bit_idx;
        shift_next      = shift;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = FETCH;
            end
            FETCH: begin
                baud_next  = '0;
                state_next = START;
            end
            START: begin
                if (baud == '0) shift_next = fifo_data;
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_next        = '0;
                        frame_done_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // frames_sent lags frame_done by one cycle so it lands with the fall of busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            baud             <= '0;
            bit_idx          <= '0;
            shift            <= '0;
            frame_done       <= 1'b0;
            tx               <= 1'b1;
            fifo_read_enable <= 1'b0;
            busy             <= 1'b0;
            frames_sent      <= '0;
        end else begin
            state            <= state_next;
            baud             <= baud_next;
            bit_idx          <= bit_next;
            shift            <= shift_next;
            frame_done       <= frame_done_next;
            tx               <= (state == START) ? 1'b0 :
                                (state == DATA)  ? shift[0] : 1'b1;
            fifo_read_enable <= (state == IDLE) && !fifo_empty;
            busy             <= (state != IDLE) || !fifo_empty;
            frames_sent      <= frames_sent + COUNT_WIDTH'(frame_done);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (1 and 2 stop bits) fed by a queue FIFO,
// checked every cycle against a frame-timeline model plus literal spot checks.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty [2] = '{1'b1, 1'b1};
    logic        rd_en [2];
    logic [7:0]  fifo_data [2];
    logic        tx [2];
    logic        busy [2];
    logic [1:0]  frames0;
    logic [15:0] frames1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] push_buf [2][$];
    int         push_rd [2] = '{0, 0};
    logic [7:0] fq [2][$];

    logic [7:0] mq [2][$];
    logic [7:0] m_pend [2][$];
    bit         m_active [2] = '{1'b0, 1'b0};
    int         m_pop_at [2] = '{0, 0};
    logic [7:0] m_byte [2];
    int         m_frames [2] = '{0, 0};

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .COUNT_WIDTH(2)) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .fifo_read_enable(rd_en[0]),
        .fifo_data(fifo_data[0]), .tx(tx[0]), .busy(busy[0]), .frames_sent(frames0)
    );

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .COUNT_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .fifo_read_enable(rd_en[1]),
        .fifo_data(fifo_data[1]), .tx(tx[1]), .busy(busy[1]), .frames_sent(frames1)
    );

    // Registered-output FIFO: data valid the cycle after a pop, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && fq[i].size() > 0) fifo_data[i] <= fq[i].pop_front();
            else fifo_data[i] <= 8'($urandom);
            while (push_rd[i] < push_buf[i].size()) begin
                fq[i].push_back(push_buf[i][push_rd[i]]);
                push_rd[i]++;
            end
            fifo_empty[i] <= (fq[i].size() == 0);
        end
    end

    function automatic int stop_bits(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int period(int i);
        return 2 + (1 + DW + stop_bits(i)) * CPB;
    endfunction

    function automatic int count_mod(int i);
        return (i == 0) ? 4 : 65536;
    endfunction

    // tx from the frame offset: 2 quiet cycles, start bit, LSB-first data, stop.
    function automatic logic exp_tx(int i);
        int k;
        if (!m_active[i]) return 1'b1;
        k = cyc - m_pop_at[i];
        if (k >= 2 && k < 2 + CPB) return 1'b0;
        if (k >= 2 + CPB && k < 2 + (1 + DW) * CPB) return m_byte[i][(k - 2 - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_active[i] = 1'b0;
                m_frames[i] = 0;
            end else begin
                if (m_active[i] && cyc == m_pop_at[i] + period(i)) begin
                    m_active[i] = 1'b0;
                    m_frames[i] = (m_frames[i] + 1) % count_mod(i);
                end
                if (!m_active[i] && mq[i].size() > 0) begin
                    m_byte[i]   = mq[i].pop_front();
                    m_pop_at[i] = cyc;
                    m_active[i] = 1'b1;
                end
            end
            while (m_pend[i].size() > 0) mq[i].push_back(m_pend[i].pop_front());
        end
    endtask

    task automatic compare_all();
        logic [31:0] fr;
        for (int i = 0; i < 2; i++) begin
            fr = (i == 0) ? 32'(frames0) : 32'(frames1);
            check_output($sformatf("rd_en%0d", i), 32'(rd_en[i]),
                         32'(m_active[i] && cyc == m_pop_at[i]));
            check_output($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_active[i]));
            check_output($sformatf("tx%0d", i), 32'(tx[i]), 32'(exp_tx(i)));
            check_output($sformatf("frames%0d", i), fr, 32'(m_frames[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic at_cycle(int n);
        if (cyc > n) check_output("schedule", 32'(cyc), 32'(n));
        while (cyc < n) step();
    endtask

    task automatic apply_stimulus(int i, logic [7:0] b);
        push_buf[i].push_back(b);
        m_pend[i].push_back(b);
    endtask

    initial begin
        bit a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int fr_seq [5] = '{1, 2, 3, 0, 1};
        int t, t2, t3, p5, guard;

        // Reset held with bytes waiting in both FIFOs.
        apply_stimulus(0, 8'hA5);
        apply_stimulus(1, 8'h00);
        for (int n = 1; n <= 3; n++) begin
            at_cycle(n);
            check_output("rst_tx", 32'(tx[0]), 32'd1);
            check_output("rst_rd_en", 32'(rd_en[0]), 32'd0);
            check_output("rst_busy", 32'(busy[0]), 32'd0);
            check_output("rst_frames", 32'(frames0), 32'd0);
        end
        reset = 1'b0;
        t = 4;

        // Single 0xA5 frame; second instance sends 0x00 with two stop bits.
        at_cycle(t);
        check_output("a5_pop", 32'(rd_en[0]), 32'd1);
        at_cycle(t + 1);
        check_output("a5_pop_once", 32'(rd_en[0]), 32'd0);
        check_output("a5_fetch_tx", 32'(tx[0]), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            at_cycle(t + k);
            check_output("a5_start", 32'(tx[0]), 32'd0);
        end
        for (int j = 0; j < 8; j++) begin
            at_cycle(t + 6 + 4 * j);
            check_output($sformatf("a5_bit%0d", j), 32'(tx[0]), 32'(a5_bits[j]));
        end
        at_cycle(t + 37);
        check_output("sb2_last_data", 32'(tx[1]), 32'd0);
        at_cycle(t + 38);
        check_output("a5_stop", 32'(tx[0]), 32'd1);
        at_cycle(t + 41);
        check_output("a5_busy_last", 32'(busy[0]), 32'd1);
        at_cycle(t + 42);
        check_output("a5_busy_fall", 32'(busy[0]), 32'd0);
        check_output("a5_frames", 32'(frames0), 32'd1);

        // Back-to-back 0x00 then 0xFF.
        apply_stimulus(0, 8'h00);
        apply_stimulus(0, 8'hFF);
        t2 = t + 44;
        at_cycle(t2);
        check_output("b2b_pop1", 32'(rd_en[0]), 32'd1);
        at_cycle(t + 45);
        check_output("sb2_stop_end", 32'(tx[1]), 32'd1);
        check_output("sb2_busy_last", 32'(busy[1]), 32'd1);
        at_cycle(t + 46);
        check_output("sb2_busy_fall", 32'(busy[1]), 32'd0);
        check_output("sb2_frames", 32'(frames1), 32'd1);
        at_cycle(t2 + 6);
        check_output("b2b_zero_bit0", 32'(tx[0]), 32'd0);
        at_cycle(t2 + 42);
        check_output("b2b_pop2", 32'(rd_en[0]), 32'd1);
        check_output("b2b_busy_held", 32'(busy[0]), 32'd1);
        check_output("b2b_frames2", 32'(frames0), 32'd2);
        at_cycle(t2 + 43);
        check_output("b2b_fetch_tx", 32'(tx[0]), 32'd1);
        at_cycle(t2 + 44);
        check_output("b2b_start2", 32'(tx[0]), 32'd0);
        at_cycle(t2 + 48);
        check_output("b2b_ff_bit0", 32'(tx[0]), 32'd1);
        at_cycle(t2 + 84);
        check_output("b2b_frames3", 32'(frames0), 32'd3);

        // Empty FIFO for 200 cycles.
        for (int k = 1; k <= 200; k++) begin
            at_cycle(t2 + 84 + k);
            check_output("idle_rd_en", 32'(rd_en[0]), 32'd0);
            check_output("idle_tx", 32'(tx[0]), 32'd1);
            check_output("idle_busy", 32'(busy[0]), 32'd0);
        end

        // Reset during data bit 3; a queued byte pops right after release.
        apply_stimulus(0, 8'h00);
        t3 = cyc + 2;
        at_cycle(t3 + 5);
        apply_stimulus(0, 8'h3C);
        at_cycle(t3 + 19);
        check_output("mid_bit3", 32'(tx[0]), 32'd0);
        reset = 1'b1;
        at_cycle(t3 + 20);
        check_output("mid_rst_tx", 32'(tx[0]), 32'd1);
        check_output("mid_rst_busy", 32'(busy[0]), 32'd0);
        check_output("mid_rst_frames", 32'(frames0), 32'd0);
        reset = 1'b0;
        p5 = t3 + 21;
        at_cycle(p5);
        check_output("post_rst_pop", 32'(rd_en[0]), 32'd1);

        // Counter wrap with a 2-bit frames_sent.
        at_cycle(p5 + 8);
        for (int k = 0; k < 4; k++) apply_stimulus(0, 8'($urandom));
        for (int k = 0; k < 5; k++) begin
            at_cycle(p5 + 42 * (k + 1));
            check_output($sformatf("wrap%0d", k), 32'(frames0), 32'(fr_seq[k]));
        end

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 11) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                reset = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++)
                    repeat ($urandom_range(0, 3)) apply_stimulus(i, 8'($urandom));
            end
            repeat ($urandom_range(1, 150)) step();
        end

        guard = 0;
        while ((m_active[0] || m_active[1] || mq[0].size() > 0 || mq[1].size() > 0 ||
                m_pend[0].size() > 0 || m_pend[1].size() > 0) && guard < 3000) begin
            step();
            guard++;
        end
        check_output("drain_timeout", 32'(guard < 3000), 32'd1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's `fifo` block. It drains bytes from the FIFO's read port and serializes each one onto a UART line as 8N1 (LSB first, configurable stop bits). It sits between the FIFO's output_data/read_enable/empty and the board TX pin. It is the reader end of the FIFO interface.

Parameters:
DATA_WIDTH, 8, width of fifo_data and of the serialized payload (bits per frame)
CLKS_PER_BIT, 868, clk cycles per UART bit; legal range 2..65535
STOP_BITS, 1, number of stop bits; legal values 1 or 2
COUNT_WIDTH, 16, width of the frames_sent counter

Ports:
clk  input  1  single clock for all logic
reset  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty flag; high means no byte available
fifo_read_enable  output  1  one-cycle pop strobe to the FIFO
fifo_data  input  DATA_WIDTH  FIFO output_data; valid the cycle after fifo_read_enable
tx  output  1  UART serial line; idle high
busy  output  1  high from the pop cycle through the last stop-bit cycle
frames_sent  output  COUNT_WIDTH  completed frames, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled on the clk edge): state=IDLE, tx=1, fifo_read_enable=0, busy=0, frames_sent=0, bit and baud counters=0, shift register=0. Reset has priority over all other activity.
- FIFO read timing: fifo_data is registered in the FIFO and valid exactly one cycle after a fifo_read_enable pulse.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE: tx=1. If fifo_empty=0, assert fifo_read_enable for this cycle only, set busy=1, and go to FETCH. Otherwise remain in IDLE.
- FETCH (1 cycle): latch fifo_data into the shift register, clear the baud counter, go to START. tx stays 1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_WIDTH bits, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, increment frames_sent, clear busy, and go to IDLE.
- Frame period, back-to-back: (2 + (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT) cycles. This is pop-cycle to pop-cycle when the FIFO stays non-empty. The first IDLE cycle after STOP may pop immediately.
- fifo_read_enable is never asserted while fifo_empty=1, and never outside IDLE. There is at most one pop per frame.
- fifo_empty changing during FETCH..STOP is ignored. A frame in progress always completes.
- Baud counter counts 0..CLKS_PER_BIT-1 and must not overflow; its width is clog2(CLKS_PER_BIT).
- frames_sent wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Reset mid-frame: tx=1 on the cycle after the reset edge and the byte in flight is dropped (it is not re-read). frames_sent returns to 0.
- All outputs are registered; tx has no combinational path from any input.

Test Plan:
1. Hold reset for 3 cycles with fifo_empty=0 -> tx=1, fifo_read_enable=0, busy=0, frames_sent=0 throughout reset.
2. CLKS_PER_BIT=4, single byte 0xA5, pop at cycle T -> fifo_read_enable high only at T; tx=0 over T+2..T+5. Data bits 1,0,1,0,0,1,0,1, each for 4 cycles, over T+6..T+37. tx=1 over T+38..T+41. busy falls and frames_sent=1 at T+42.
3. Bytes 0x00 then 0xFF with the FIFO non-empty throughout, CLKS_PER_BIT=4 -> pops at T and T+42. The second start bit begins at T+44. frames_sent=2 at T+84.
4. fifo_empty held at 1 for 200 cycles -> fifo_read_enable stays 0, tx stays 1, busy stays 0.
5. Assert reset during bit 3 of a frame -> tx=1 and state=IDLE on the next cycle, frames_sent=0. After release with fifo_empty=0, a fresh pop occurs on the first post-reset cycle.
6. COUNT_WIDTH=2, send 5 frames -> frames_sent sequence is 1,2,3,0,1. STOP_BITS=2 variant: stop high for exactly 8 cycles at CLKS_PER_BIT=4.
